// File: rtl/bcd_conv_sched.sv
// ============================================================================
// bcd_conv_sched : four-channel round-robin binary-to-BCD converter
// Revision       : 1.0
// ============================================================================
`default_nettype none

module bcd_conv_sched #(
  parameter int W = 12
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [3:0]     req,
  input  logic [4*W-1:0] din,
  output logic [3:0]     grant,
  output logic           busy,
  output logic           done,
  output logic [1:0]     done_ch,
  output logic [15:0]    bcd
);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    CONV = 1'b1
  } state_t;

  state_t         r_state;
  logic [1:0]     r_ptr;
  logic [1:0]     r_ch;
  logic [W-1:0]   r_r;
  logic [3:0]     r_d3;
  logic [3:0]     r_d2;
  logic [3:0]     r_d1;
  logic [3:0]     r_grant;
  logic           r_done;
  logic [1:0]     r_done_ch;
  logic [15:0]    r_bcd;

  logic [1:0]     w_sel;
  logic [1:0]     w_idx;
  logic           w_found;
  logic [W-1:0]   w_opnd;
  logic [13:0]    w_rx;

  // Scan from ptr+3 down to ptr so the lowest offset with a request wins.
  always_comb begin
    w_sel   = r_ptr;
    w_idx   = r_ptr;
    w_found = 1'b0;
    for (int k = 3; k >= 0; k--) begin
      w_idx = r_ptr + 2'(k);
      if (req[w_idx]) begin
        w_sel   = w_idx;
        w_found = 1'b1;
      end
    end
  end

  assign w_opnd = din[32'(w_sel)*W +: W];
  assign w_rx   = 14'(r_r);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_ptr     <= 2'd0;
      r_ch      <= 2'd0;
      r_r       <= '0;
      r_d3      <= 4'd0;
      r_d2      <= 4'd0;
      r_d1      <= 4'd0;
      r_grant   <= 4'd0;
      r_done    <= 1'b0;
      r_done_ch <= 2'd0;
      r_bcd     <= 16'h0000;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_found) begin
            r_ch    <= w_sel;
            r_r     <= w_opnd;
            r_d3    <= 4'd0;
            r_d2    <= 4'd0;
            r_d1    <= 4'd0;
            r_grant <= 4'd1 << w_sel;
            r_state <= CONV;
          end
        end
        CONV: begin
          // One decimal weight is peeled off per cycle, largest first.
          if (w_rx > 14'd999) begin
            r_r  <= W'(w_rx - 14'd1000);
            r_d3 <= r_d3 + 4'd1;
          end else if (w_rx > 14'd99) begin
            r_r  <= W'(w_rx - 14'd100);
            r_d2 <= r_d2 + 4'd1;
          end else if (w_rx > 14'd9) begin
            r_r  <= W'(w_rx - 14'd10);
            r_d1 <= r_d1 + 4'd1;
          end else begin
            r_bcd     <= {r_d3, r_d2, r_d1, r_r[3:0]};
            r_done    <= 1'b1;
            r_done_ch <= r_ch;
            r_grant   <= 4'd0;
            r_ptr     <= r_ch + 2'd1;
            r_state   <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign grant   = r_grant;
  assign busy    = (r_state == CONV);
  assign done    = r_done;
  assign done_ch = r_done_ch;
  assign bcd     = r_bcd;

endmodule

`default_nettype wire

// File: tb/tb_bcd_conv_sched.sv
// ============================================================================
// tb_bcd_conv_sched : self-checking bench for bcd_conv_sched
// Revision          : 1.0
// ============================================================================
`default_nettype none

module tb_bcd_conv_sched;

  localparam int W = 12;

  logic           clk = 1'b0;
  logic           rst;
  logic [3:0]     req;
  logic [4*W-1:0] din;
  logic [3:0]     grant;
  logic           busy;
  logic           done;
  logic [1:0]     done_ch;
  logic [15:0]    bcd;

  int errors = 0;
  int checks = 0;
  int m_ptr  = 0;

  bcd_conv_sched #(.W(W)) dut (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .din     (din),
    .grant   (grant),
    .busy    (busy),
    .done    (done),
    .done_ch (done_ch),
    .bcd     (bcd)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: decimal digits and cycle count straight from the value.
  function automatic logic [15:0] ref_bcd(input int v);
    ref_bcd = {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  function automatic int ref_lat(input int v);
    ref_lat = v / 1000 + (v % 1000) / 100 + (v % 100) / 10 + 1;
  endfunction

  function automatic int ref_pick(input logic [3:0] mask, input int ptr);
    ref_pick = -1;
    for (int k = 3; k >= 0; k--)
      if (mask[(ptr + k) % 4]) ref_pick = (ptr + k) % 4;
  endfunction

  task automatic set_op(input int ch, input int v);
    din[ch*W +: W] = W'(v);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    req = 4'd0;
    @(negedge clk);
    rst = 1'b0;
    m_ptr = 0;
    check("rst_grant", 32'(grant), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_done_ch", 32'(done_ch), 0);
    check("rst_bcd", 32'(bcd), 0);
  endtask

  // Called at a negedge with the DUT idle; runs one full conversion.
  task automatic serve(input logic [3:0] mask, input bit scramble);
    int ec, v, n;
    req = mask;
    ec  = ref_pick(mask, m_ptr);
    v   = int'(din[ec*W +: W]);
    n   = 0;
    do begin
      @(negedge clk);
      n++;
      if (n == 1) check("done_pulse", 32'(done), 0);
    end while (grant == 4'd0 && n < 50);
    check("grant_wait", n, 1);
    check("grant", 32'(grant), 32'(4'd1 << ec));
    check("busy", 32'(busy), 1);
    n = 0;
    while (!done && n < 60) begin
      if (scramble) begin
        din = {$urandom, $urandom};
        req = 4'($urandom);
      end
      @(negedge clk);
      n++;
      if (!done && grant != (4'd1 << ec)) check("grant_hold", 32'(grant), 32'(4'd1 << ec));
    end
    check("latency", n, ref_lat(v));
    check("bcd", 32'(bcd), 32'(ref_bcd(v)));
    check("done_ch", 32'(done_ch), ec);
    check("grant_done", 32'(grant), 0);
    check("busy_done", 32'(busy), 0);
    m_ptr = (ec + 1) % 4;
  endtask

  initial begin
    int ops[5];
    ops = '{0, 9, 10, 999, 4095};
    rst = 1'b1;
    req = 4'd0;
    din = '0;
    repeat (2) @(negedge clk);
    do_reset();

    set_op(0, 1234);
    serve(4'b0001, 1'b0);

    for (int i = 0; i < 5; i++) begin
      set_op(2, ops[i]);
      serve(4'b0100, 1'b0);
    end

    do_reset();
    for (int c = 0; c < 4; c++) set_op(c, 100 * c + 7 * c + 1);
    for (int i = 0; i < 5; i++) serve(4'b1111, 1'b0);

    do_reset();
    serve(4'b0001, 1'b0);
    serve(4'b0101, 1'b0);
    serve(4'b0101, 1'b0);

    // Operand and request churn during conversion must not leak into the result.
    set_op(0, 3579);
    serve(4'b0001, 1'b1);

    // Abort a conversion with a one-cycle reset.
    do_reset();
    set_op(0, 4095);
    req = 4'b0001;
    @(negedge clk);
    check("abort_grant", 32'(grant), 1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("abort_nodone", 32'(done), 0);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    m_ptr = 0;
    check("abort_grant0", 32'(grant), 0);
    check("abort_busy", 32'(busy), 0);
    check("abort_done", 32'(done), 0);
    check("abort_bcd", 32'(bcd), 0);
    set_op(1, 55);
    serve(4'b0011, 1'b0);

    for (int i = 0; i < 40; i++) begin
      logic [3:0] m;
      m = 4'($urandom_range(1, 15));
      for (int c = 0; c < 4; c++) set_op(c, int'($urandom_range(0, (1 << W) - 1)));
      serve(m, ($urandom % 2) == 1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
